axis_merge2_1: RTL and testbench

- Frame-aware 2-to-1 AXI-Stream merger with a registered output.
- It sits directly downstream of the 1-to-2 AXIS distributor, or of the two processing branches fed by it, and recombines both branches into one stream.
- It arbitrates between the two slave ports and holds the grant until the tlast beat of the current frame, so frames never interleave.
- It has full-throughput handshaking and one register stage on the output.

---
 rtl/axis_merge2_1.sv | 103 ++++++++++
 tb/tb_axis_merge2_1.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_merge2_1.sv
// Frame-aware 2-to-1 AXI-Stream merger: the grant is held from the first beat
// to the tlast beat of a frame, and the merged beat leaves through one output register.
module axis_merge2_1 #(
  parameter int unsigned width = 1,
  parameter bit          rr    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic [width-1:0] s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [1:0]       grant
);

  // Handshake: a beat moves on any port only in a cycle where both tvalid and
  // tready are 1 at the rising edge. The master holds tdata/tlast/tvalid
  // stable while tvalid=1 and tready=0. The tready of a slave port depends
  // combinationally on m_axis_tready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_owner;   // 0: s0 finished the last frame, 1: s1 did
  logic             out_free;
  logic             accept;
  logic             accept_last;
  logic [width-1:0] accept_data;

  // The output register can take a beat when it is empty or draining this cycle.
  assign out_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    state_next     = state;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;
    accept         = 1'b0;
    accept_data    = s0_axis_tdata;
    accept_last    = s0_axis_tlast;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_next = (rr && !last_owner) ? LOCK1 : LOCK0;
        end else if (s0_axis_tvalid) begin
          state_next = LOCK0;
        end else if (s1_axis_tvalid) begin
          state_next = LOCK1;
        end
      end
      LOCK0: begin
        grant          = 2'b01;
        s0_axis_tready = out_free;
        accept         = s0_axis_tvalid && out_free;
        if (accept && s0_axis_tlast) state_next = IDLE;
      end
      LOCK1: begin
        grant          = 2'b10;
        s1_axis_tready = out_free;
        accept         = s1_axis_tvalid && out_free;
        accept_data    = s1_axis_tdata;
        accept_last    = s1_axis_tlast;
        if (accept && s1_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && accept_last) last_owner <= (state == LOCK1);
      // A new beat overwrites a draining one, so tvalid stays high back to back.
      if (accept) begin
        m_axis_tdata  <= accept_data;
        m_axis_tlast  <= accept_last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_merge2_1.sv
// Directed bench for axis_merge2_1: round-robin instance driven from beat queues,
// plus a fixed-priority instance held under continuous requests.
module tb_axis_merge2_1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] s0_data, s1_data, m_data;
  logic         s0_valid, s0_last, s0_ready;
  logic         s1_valid, s1_last, s1_ready;
  logic         m_valid, m_last, m_ready;
  logic [1:0]   grant;

  logic [W-1:0] r_s0_data, r_s1_data, r_m_data;
  logic         r_s0_valid, r_s0_last, r_s0_ready;
  logic         r_s1_valid, r_s1_last, r_s1_ready;
  logic         r_m_valid, r_m_last, r_m_ready;
  logic [1:0]   r_grant;

  logic [W:0]   src0_q[$];
  logic [W:0]   src1_q[$];
  logic [W:0]   exp_q[$];
  logic [1:0]   g_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int out_count = 0;
  int first_out = -1;
  int last_out = -1;
  int r_cnt = 0;
  logic t3_on = 1'b0;

  always #5 clk = ~clk;

  axis_merge2_1 #(.width(W), .rr(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(s0_data), .s0_axis_tvalid(s0_valid), .s0_axis_tlast(s0_last), .s0_axis_tready(s0_ready),
    .s1_axis_tdata(s1_data), .s1_axis_tvalid(s1_valid), .s1_axis_tlast(s1_last), .s1_axis_tready(s1_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .grant(grant)
  );

  axis_merge2_1 #(.width(W), .rr(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(r_s0_data), .s0_axis_tvalid(r_s0_valid), .s0_axis_tlast(r_s0_last), .s0_axis_tready(r_s0_ready),
    .s1_axis_tdata(r_s1_data), .s1_axis_tvalid(r_s1_valid), .s1_axis_tlast(r_s1_last), .s1_axis_tready(r_s1_ready),
    .m_axis_tdata(r_m_data), .m_axis_tvalid(r_m_valid), .m_axis_tlast(r_m_last), .m_axis_tready(r_m_ready),
    .grant(r_grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int port, input logic [W-1:0] d, input logic l);
    if (port == 0) src0_q.push_back({l, d});
    else src1_q.push_back({l, d});
  endtask

  task automatic push_frame(input int port, input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) push_beat(port, base + W'(i), (i == n - 1));
  endtask

  task automatic exp_frame(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + W'(i)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size() + src0_q.size() + src1_q.size(), 0);
  endtask

  // Sources: a beat is retired once tvalid & tready were seen before the edge.
  initial begin : source
    logic f0, f1;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    forever begin
      @(negedge clk);
      f0 = s0_valid && s0_ready;
      f1 = s1_valid && s1_ready;
      @(posedge clk);
      #1;
      if (f0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (f1 && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src0_q.size() > 0) begin
        {s0_last, s0_data} = src0_q[0];
        s0_valid = 1'b1;
      end else begin
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
      end
      if (src1_q.size() > 0) begin
        {s1_last, s1_data} = src1_q[0];
        s1_valid = 1'b1;
      end else begin
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
      end
    end
  end

  // Per-cycle checker: tready rule, grant encoding, output hold, beat order.
  initial begin : compare
    logic         prev_v, prev_r, prev_l;
    logic [W-1:0] prev_d;
    logic [1:0]   prev_g;
    logic [W:0]   e;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0; prev_g = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        check("grant_onehot", {31'd0, grant == 2'b11}, 0);
        check("s0_ready_rule", {31'd0, s0_ready}, {31'd0, (grant == 2'b01) && (!m_valid || m_ready)});
        check("s1_ready_rule", {31'd0, s1_ready}, {31'd0, (grant == 2'b10) && (!m_valid || m_ready)});
        if (prev_v && !prev_r) begin
          check("hold_valid", {31'd0, m_valid}, 1);
          check("hold_beat", {23'd0, m_last, m_data}, {23'd0, prev_l, prev_d});
        end
        if (grant != prev_g) g_q.push_back(grant);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL m_beat: got 0x%0h expected nothing (cycle %0d)", {m_last, m_data}, cyc);
          end else begin
            e = exp_q.pop_front();
            check("m_beat", {23'd0, m_last, m_data}, {23'd0, e});
          end
          out_count++;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end
        if (t3_on) begin
          check("fixed_s1_ready", {31'd0, r_s1_ready}, 0);
          check("fixed_grant_s1", {31'd0, r_grant == 2'b10}, 0);
          if (r_m_valid) check("fixed_data", {23'd0, r_m_last, r_m_data}, {23'd0, 1'b1, 8'h5A});
          if (r_m_valid && r_m_ready) r_cnt++;
        end
      end
      prev_v = rst_n && m_valid;
      prev_r = m_ready;
      prev_d = m_data;
      prev_l = m_last;
      prev_g = rst_n ? grant : 2'b00;
    end
  end

  initial begin : stimulus
    logic [W-1:0] v4[4];
    logic [1:0]   g_exp[16];
    int           start;
    bit           found;
    rst_n = 1'b0;
    m_ready = 1'b1;
    r_m_ready = 1'b1;
    r_s0_valid = 1'b0; r_s0_data = 8'h5A; r_s0_last = 1'b1;
    r_s1_valid = 1'b0; r_s1_data = 8'hB0; r_s1_last = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_data", {24'd0, m_data}, 0);
    check("rst_m_last", {31'd0, m_last}, 0);
    check("rst_readies", {30'd0, s0_ready, s1_ready}, 0);
    check("rst_grant", {30'd0, grant}, 0);
    #2 rst_n = 1'b1;

    // Test 1: 4-beat s0 frame, latency and grant
    push_frame(0, 8'h01, 4);
    exp_frame(8'h01, 4);
    @(negedge clk);
    check("t1_ready_c0", {31'd0, s0_ready}, 0);
    check("t1_grant_c0", {30'd0, grant}, 0);
    @(negedge clk);
    check("t1_ready_c1", {31'd0, s0_ready}, 1);
    check("t1_grant_c1", {30'd0, grant}, 2'b01);
    check("t1_mvalid_c1", {31'd0, m_valid}, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t1_m_valid", {31'd0, m_valid}, 1);
      check("t1_m_data", {24'd0, m_data}, k);
      check("t1_m_last", {31'd0, m_last}, (k == 4) ? 1 : 0);
      check("t1_grant", {30'd0, grant}, (k == 4) ? 0 : 1);
    end
    wait_done("t1_done");

    // Test 2: round-robin with continuous 3-beat frames on both ports
    do_reset();
    first_out = -1;
    push_frame(0, 8'hA0, 3); push_frame(0, 8'hA0, 3);
    push_frame(1, 8'hB0, 3); push_frame(1, 8'hB0, 3);
    exp_frame(8'hA0, 3); exp_frame(8'hB0, 3); exp_frame(8'hA0, 3); exp_frame(8'hB0, 3);
    wait_done("t2_done");
    check("t2_span", last_out - first_out, 14);

    // Test 3: fixed priority, both ports of the second instance always requesting
    @(posedge clk);
    #1 r_s0_valid = 1'b1; r_s1_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 t3_on = 1'b1;
    r_cnt = 0;
    repeat (20) @(posedge clk);
    #1 t3_on = 1'b0;
    check("t3_beats", r_cnt, 10);
    r_s0_valid = 1'b0; r_s1_valid = 1'b0;

    // Test 4: back-pressure after beat 2
    do_reset();
    v4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push_beat(0, v4[i], (i == 3));
      exp_q.push_back({(i == 3), v4[i]});
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_valid && m_data == 8'h22) found = 1'b1;
    end
    check("t4_found_22", {31'd0, found}, 1);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_data", {24'd0, m_data}, 8'h22);
      check("t4_hold_valid", {31'd0, m_valid}, 1);
      check("t4_s0_ready", {31'd0, s0_ready}, 0);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done("t4_done");

    // Test 5: alternating single-beat frames
    do_reset();
    first_out = -1;
    g_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_beat(0, 8'h50 + W'(i), 1'b1);
      push_beat(1, 8'h60 + W'(i), 1'b1);
      exp_q.push_back({1'b1, 8'h50 + W'(i)});
      exp_q.push_back({1'b1, 8'h60 + W'(i)});
    end
    wait_done("t5_done");
    check("t5_span", last_out - first_out, 14);
    g_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00,
              2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    check("t5_grant_len", g_q.size(), 16);
    for (int i = 0; i < 16 && i < g_q.size(); i++) check("t5_grant_seq", {30'd0, g_q[i]}, {30'd0, g_exp[i]});

    // Test 6: asynchronous reset in the middle of a 6-beat s1 frame
    do_reset();
    push_frame(1, 8'hC1, 6);
    exp_frame(8'hC1, 6);
    start = out_count;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      if (out_count - start >= 2) found = 1'b1;
    end
    check("t6_two_beats", {31'd0, found}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_m_valid", {31'd0, m_valid}, 0);
    check("t6_m_data", {24'd0, m_data}, 0);
    check("t6_m_last", {31'd0, m_last}, 0);
    check("t6_grant", {30'd0, grant}, 0);
    check("t6_readies", {30'd0, s0_ready, s1_ready}, 0);
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    push_frame(0, 8'hD1, 3);
    push_frame(1, 8'hE1, 1);
    exp_frame(8'hD1, 3);
    exp_frame(8'hE1, 1);
    repeat (2) @(negedge clk);
    check("t6_first_grant", {30'd0, grant}, 2'b01);
    wait_done("t6_done");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
